// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for a single register-file write port shared by the pipeline
// and a long-latency unit, with a pending-register scoreboard and read-hazard stall.
module regfile_wb_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        ll_issue,
  input  logic [4:0]  ll_issue_addr,
  input  logic        ll_valid,
  input  logic [4:0]  ll_waddr,
  input  logic [31:0] ll_wdata,
  output logic        ll_ready,
  input  logic        re1,
  input  logic        re2,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] busy,
  output logic        err
);

  logic        pipe_eff;
  logic        drain;
  logic        accept;
  logic        buf_full;
  logic [4:0]  buf_addr;
  logic [31:0] buf_data;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] busy_next;
  logic        issue_err;
  logic        result_err;
  logic        pipe_err;

  // Writes to r0 are discarded up front so they never steal the port from the buffer.
  always_comb begin
    pipe_eff = pipe_we && (pipe_waddr != 5'd0);
    drain    = buf_full && !pipe_eff;
    ll_ready = !rst && (!buf_full || drain);
    accept   = ll_valid && ll_ready;
  end

  always_comb begin
    set_mask   = '0;
    clr_mask   = '0;
    if (ll_issue && (ll_issue_addr != 5'd0))
      set_mask = 32'd1 << ll_issue_addr;
    if (drain)
      clr_mask = 32'd1 << buf_addr;
    // Set is applied after clear so a same-cycle reissue keeps the register pending.
    busy_next  = ((busy & ~clr_mask) | set_mask) & ~32'd1;
    issue_err  = ll_issue && (ll_issue_addr != 5'd0) && busy[ll_issue_addr]
                 && !clr_mask[ll_issue_addr];
    result_err = accept && !busy[ll_waddr];
    pipe_err   = pipe_eff && busy[pipe_waddr];
  end

  assign stall = !rst && ((re1 && (raddr1 != 5'd0) && busy[raddr1]) ||
                          (re2 && (raddr2 != 5'd0) && busy[raddr2]));

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_addr <= ll_waddr;
      buf_data <= ll_wdata;
    end else if (drain) begin
      buf_full <= 1'b0;
    end
  end

  // Port register: idle cycles drop we but keep the last address and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (pipe_eff) begin
      we    <= 1'b1;
      waddr <= pipe_waddr;
      wdata <= pipe_wdata;
    end else if (drain) begin
      we    <= 1'b1;
      waddr <= buf_addr;
      wdata <= buf_data;
    end else begin
      we    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_next;
      err  <= err || issue_err || result_err || pipe_err;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed self-checking bench for regfile_wb_sched: arbitration, latency,
// scoreboard set/clear, stall, sticky error and reset behaviour.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        ll_issue;
  logic [4:0]  ll_issue_addr;
  logic        ll_valid;
  logic [4:0]  ll_waddr;
  logic [31:0] ll_wdata;
  logic        ll_ready;
  logic        re1;
  logic        re2;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] busy;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_wb_sched dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .ll_issue(ll_issue), .ll_issue_addr(ll_issue_addr),
    .ll_valid(ll_valid), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata), .ll_ready(ll_ready),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .stall(stall), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    ll_issue = 1'b0; ll_issue_addr = '0;
    ll_valid = 1'b0; ll_waddr = '0; ll_wdata = '0;
    re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;

    // Reset state
    tick(); tick();
    check_output("rst_we", {31'd0, we}, 32'd0);
    check_output("rst_waddr", {27'd0, waddr}, 32'd0);
    check_output("rst_wdata", wdata, 32'd0);
    check_output("rst_busy", busy, 32'd0);
    check_output("rst_err", {31'd0, err}, 32'd0);
    check_output("rst_ll_ready", {31'd0, ll_ready}, 32'd0);
    check_output("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    settle();
    check_output("post_rst_ll_ready", {31'd0, ll_ready}, 32'd1);

    // Pipeline write appears one cycle later, then idle holds address/data
    pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h1234;
    tick();
    pipe_we = 1'b0;
    check_output("pipe_we", {31'd0, we}, 32'd1);
    check_output("pipe_waddr", {27'd0, waddr}, 32'd5);
    check_output("pipe_wdata", wdata, 32'h1234);
    tick();
    check_output("idle_we", {31'd0, we}, 32'd0);
    check_output("idle_waddr_hold", {27'd0, waddr}, 32'd5);
    check_output("idle_wdata_hold", wdata, 32'h1234);

    // Issue to r0 is ignored
    ll_issue = 1'b1; ll_issue_addr = 5'd0;
    tick();
    ll_issue = 1'b0;
    check_output("issue_r0_busy", busy, 32'd0);
    check_output("issue_r0_err", {31'd0, err}, 32'd0);

    // Long-latency path to r7 with read hazard
    ll_issue = 1'b1; ll_issue_addr = 5'd7;
    tick();
    ll_issue = 1'b0;
    check_output("ll7_busy", busy, 32'h0000_0080);
    re1 = 1'b1; raddr1 = 5'd7;
    re2 = 1'b1; raddr2 = 5'd3;
    settle();
    check_output("ll7_stall", {31'd0, stall}, 32'd1);
    ll_valid = 1'b1; ll_waddr = 5'd7; ll_wdata = 32'hDEAD;
    settle();
    check_output("ll7_ready_empty", {31'd0, ll_ready}, 32'd1);
    tick();
    ll_valid = 1'b0;
    settle();
    check_output("ll7_ready_draining", {31'd0, ll_ready}, 32'd1);
    check_output("ll7_we_not_yet", {31'd0, we}, 32'd0);
    check_output("ll7_stall_still", {31'd0, stall}, 32'd1);
    tick();
    check_output("ll7_we", {31'd0, we}, 32'd1);
    check_output("ll7_waddr", {27'd0, waddr}, 32'd7);
    check_output("ll7_wdata", wdata, 32'hDEAD);
    check_output("ll7_busy_clear", busy, 32'd0);
    check_output("ll7_stall_clear", {31'd0, stall}, 32'd0);
    check_output("ll7_err", {31'd0, err}, 32'd0);
    re1 = 1'b0; re2 = 1'b0;

    // Buffer starved by three pipeline writes, drains on the fourth cycle
    ll_issue = 1'b1; ll_issue_addr = 5'd10;
    tick();
    ll_issue = 1'b0;
    ll_valid = 1'b1; ll_waddr = 5'd10; ll_wdata = 32'hA0A0;
    tick();
    ll_valid = 1'b0;
    pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h1111;
    settle();
    check_output("starve1_ll_ready", {31'd0, ll_ready}, 32'd0);
    tick();
    check_output("starve1_waddr", {27'd0, waddr}, 32'd1);
    pipe_waddr = 5'd2; pipe_wdata = 32'h2222;
    settle();
    check_output("starve2_ll_ready", {31'd0, ll_ready}, 32'd0);
    tick();
    check_output("starve2_wdata", wdata, 32'h2222);
    pipe_waddr = 5'd3; pipe_wdata = 32'h3333;
    settle();
    check_output("starve3_ll_ready", {31'd0, ll_ready}, 32'd0);
    tick();
    check_output("starve3_waddr", {27'd0, waddr}, 32'd3);
    check_output("starve3_busy", busy, 32'h0000_0400);
    pipe_we = 1'b0;
    settle();
    check_output("starve4_ll_ready", {31'd0, ll_ready}, 32'd1);
    tick();
    check_output("starve_drain_we", {31'd0, we}, 32'd1);
    check_output("starve_drain_waddr", {27'd0, waddr}, 32'd10);
    check_output("starve_drain_wdata", wdata, 32'hA0A0);
    check_output("starve_busy_clear", busy, 32'd0);

    // Pipe write to r0 does not consume the port; the buffer drains instead
    ll_issue = 1'b1; ll_issue_addr = 5'd12;
    tick();
    ll_issue = 1'b0;
    ll_valid = 1'b1; ll_waddr = 5'd12; ll_wdata = 32'hC0DE;
    tick();
    ll_valid = 1'b0;
    pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hFFFF;
    settle();
    check_output("r0_ll_ready", {31'd0, ll_ready}, 32'd1);
    tick();
    pipe_we = 1'b0;
    check_output("r0_drain_waddr", {27'd0, waddr}, 32'd12);
    check_output("r0_drain_wdata", wdata, 32'hC0DE);
    check_output("r0_err", {31'd0, err}, 32'd0);

    // Reissue during drain keeps the register pending; a second reissue is an error
    ll_issue = 1'b1; ll_issue_addr = 5'd9;
    tick();
    ll_issue = 1'b0;
    ll_valid = 1'b1; ll_waddr = 5'd9; ll_wdata = 32'h9999;
    tick();
    ll_valid = 1'b0;
    ll_issue = 1'b1; ll_issue_addr = 5'd9;
    tick();
    check_output("reissue_busy", busy, 32'h0000_0200);
    check_output("reissue_err", {31'd0, err}, 32'd0);
    check_output("reissue_drain_waddr", {27'd0, waddr}, 32'd9);
    tick();
    ll_issue = 1'b0;
    check_output("double_issue_err", {31'd0, err}, 32'd1);
    tick();
    check_output("err_sticky", {31'd0, err}, 32'd1);

    // Reset mid-operation with buffer full and busy = 0xF00
    ll_issue = 1'b1; ll_issue_addr = 5'd8;
    tick();
    ll_issue_addr = 5'd10;
    tick();
    ll_issue_addr = 5'd11;
    tick();
    ll_issue = 1'b0;
    check_output("pre_rst_busy", busy, 32'h0000_0F00);
    ll_valid = 1'b1; ll_waddr = 5'd8; ll_wdata = 32'h8888;
    tick();
    ll_valid = 1'b0;
    re1 = 1'b1; raddr1 = 5'd9;
    rst = 1'b1;
    settle();
    check_output("mid_rst_ll_ready", {31'd0, ll_ready}, 32'd0);
    check_output("mid_rst_stall", {31'd0, stall}, 32'd0);
    tick();
    check_output("mid_rst_busy", busy, 32'd0);
    check_output("mid_rst_we", {31'd0, we}, 32'd0);
    check_output("mid_rst_err", {31'd0, err}, 32'd0);
    check_output("mid_rst_ll_ready_hold", {31'd0, ll_ready}, 32'd0);
    rst = 1'b0;
    settle();
    check_output("after_rst_ll_ready", {31'd0, ll_ready}, 32'd1);
    check_output("after_rst_stall", {31'd0, stall}, 32'd0);
    tick();
    check_output("after_rst_buffer_discarded", {31'd0, we}, 32'd0);
    re1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
